dot_mac_pipe: RTL and testbench

Parametrised, pipelined unsigned dot-product and multiply-accumulate engine. It replaces the fixed two-lane, 2-bit product-sum datapath with a configurable one: lane count, operand width and accumulator width are parameters. It adds a valid qualifier, an optional running accumulation with clear, and saturation with a sticky overflow flag. It sits in the PL datapath between the operand registers and the result capture logic, clocked by the single fabric clock.

---
 rtl/dot_mac_pkg.sv | 33 +++
 rtl/dot_mac_tree.sv | 34 +++
 rtl/dot_mac_pipe.sv | 115 +++++++++++
 tb/tb_dot_mac_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_mac_pkg.sv
// Shared types and width helpers for the dot_mac_pipe dot-product / MAC engine.
package dot_mac_pkg;

    // Each lane product is this many operand widths wide.
    localparam int unsigned PROD_SCALE = 2;

    typedef struct packed {
        logic valid;
        logic acc_en;
        logic clear;
    } ctrl_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned span;
        res  = 0;
        span = 1;
        while (span < value) begin
            span = span * 2;
            res  = res + 1;
        end
        return res;
    endfunction

    function automatic int unsigned sum_width(input int unsigned w, input int unsigned n);
        return PROD_SCALE * w + clog2(n);
    endfunction

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
        return lane * w;
    endfunction

endpackage

// File: rtl/dot_mac_tree.sv
// Balanced combinational adder tree over N lane products; odd lane counts are zero-padded.
module dot_mac_tree
    import dot_mac_pkg::*;
#(
    parameter int unsigned W     = 2,
    parameter int unsigned N     = 2,
    parameter int unsigned SUM_W = sum_width(W, N)
) (
    input  logic [N*PROD_SCALE*W-1:0] prods,
    output logic [SUM_W-1:0]          sum
);

    localparam int unsigned PW     = PROD_SCALE * W;
    localparam int unsigned LEVELS = clog2(N);
    localparam int unsigned LEAVES = 1 << LEVELS;

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic [SUM_W-1:0] node [LEAVES >> l];
        for (genvar i = 0; i < (LEAVES >> l); i++) begin : g_node
            if (l == 0) begin : g_leaf
                if (i < N) begin : g_lane
                    assign node[i] = SUM_W'(prods[lane_lsb(i, PW) +: PW]);
                end else begin : g_pad
                    assign node[i] = '0;
                end
            end else begin : g_add
                assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
            end
        end
    end

    assign sum = g_lvl[LEVELS].node[0];

endmodule

// File: rtl/dot_mac_pipe.sv
// Three-stage unsigned dot-product engine with optional saturating accumulation.
module dot_mac_pipe
    import dot_mac_pkg::*;
#(
    parameter int unsigned W     = 2,
    parameter int unsigned N     = 2,
    parameter int unsigned ACC_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_valid,
    input  logic             Acc_en,
    input  logic             Clear,
    input  logic [N*W-1:0]   A_vec,
    input  logic [N*W-1:0]   B_vec,
    output logic [ACC_W-1:0] Out,
    output logic             Out_valid,
    output logic             Ovf
);

    localparam int unsigned PW    = PROD_SCALE * W;
    localparam int unsigned SUM_W = sum_width(W, N);
    localparam int unsigned EXT_W = ACC_W + 1;

    if (ACC_W < SUM_W) begin : g_acc_w_check
        $error("dot_mac_pipe: ACC_W must be >= 2*W + clog2(N)");
    end

    logic [N*PW-1:0]  prod_d, prod_q;
    ctrl_t            ctrl1_q, ctrl2_q;
    logic [SUM_W-1:0] tree_sum, sum_q;
    logic [ACC_W-1:0] acc_d, acc_q, out_d, out_q;
    logic             ovf_d, ovf_q, out_valid_q;
    logic [EXT_W-1:0] acc_ext;

    always_comb begin
        prod_d = '0;
        for (int i = 0; i < N; i++) begin
            prod_d[lane_lsb(i, PW) +: PW] = PW'(A_vec[lane_lsb(i, W) +: W])
                                          * PW'(B_vec[lane_lsb(i, W) +: W]);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            prod_q  <= '0;
            ctrl1_q <= '0;
        end else begin
            prod_q  <= prod_d;
            ctrl1_q <= '{valid: In_valid, acc_en: Acc_en, clear: Clear};
        end
    end

    dot_mac_tree #(
        .W     (W),
        .N     (N),
        .SUM_W (SUM_W)
    ) u_tree (
        .prods (prod_q),
        .sum   (tree_sum)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sum_q   <= '0;
            ctrl2_q <= '0;
        end else begin
            sum_q   <= tree_sum;
            ctrl2_q <= ctrl1_q;
        end
    end

    // The extra top bit of acc_ext is the overflow indicator for saturation.
    always_comb begin
        acc_d   = acc_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        acc_ext = {1'b0, acc_q} + EXT_W'(sum_q);
        if (ctrl2_q.valid) begin
            if (!ctrl2_q.acc_en) begin
                out_d = ACC_W'(sum_q);
            end else if (ctrl2_q.clear) begin
                acc_d = ACC_W'(sum_q);
                out_d = ACC_W'(sum_q);
                ovf_d = 1'b0;
            end else if (acc_ext[ACC_W]) begin
                acc_d = '1;
                out_d = '1;
                ovf_d = 1'b1;
            end else begin
                acc_d = acc_ext[ACC_W-1:0];
                out_d = acc_ext[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc_q       <= '0;
            out_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_q       <= out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= ctrl2_q.valid;
        end
    end

    assign Out       = out_q;
    assign Out_valid = out_valid_q;
    assign Ovf       = ovf_q;

endmodule

// File: tb/tb_dot_mac_pipe.sv
// Self-checking bench for dot_mac_pipe (W=2, N=2, ACC_W=8) against a sample-level model.
module tb_dot_mac_pipe;

    localparam int W     = 2;
    localparam int N     = 2;
    localparam int ACC_W = 8;
    localparam logic [3:0] V5  = 4'b1001;  // lanes (1,2): 1*1 + 2*2 = 5
    localparam logic [3:0] V18 = 4'b1111;  // lanes (3,3): 9 + 9 = 18

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             acc_en;
    logic             clear;
    logic [N*W-1:0]   a_vec;
    logic [N*W-1:0]   b_vec;
    logic [ACC_W-1:0] out;
    logic             out_valid;
    logic             ovf;

    int checks;
    int errors;

    // Sample-level model: state is updated when a sample is issued; each issued slot
    // becomes visible at the outputs two edges after the edge that captures it.
    int         m_acc;
    logic [7:0] m_out;
    logic       m_ovf;
    logic       pend_v [2];
    logic [7:0] pend_o [2];
    logic       pend_f [2];
    logic       e_v;
    logic [7:0] e_out;
    logic       e_ovf;

    dot_mac_pipe #(
        .W     (W),
        .N     (N),
        .ACC_W (ACC_W)
    ) dut (
        .Clk       (clk),
        .Rst       (rst),
        .In_valid  (in_valid),
        .Acc_en    (acc_en),
        .Clear     (clear),
        .A_vec     (a_vec),
        .B_vec     (b_vec),
        .Out       (out),
        .Out_valid (out_valid),
        .Ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic v, input logic ae, input logic cl,
                        input logic [3:0] a, input logic [3:0] b);
        int s;
        rst = r; in_valid = v; acc_en = ae; clear = cl; a_vec = a; b_vec = b;
        @(posedge clk);
        #1;
        if (r) begin
            m_acc = 0; m_out = 8'd0; m_ovf = 1'b0;
            e_v = 1'b0; e_out = 8'd0; e_ovf = 1'b0;
            for (int i = 0; i < 2; i++) begin
                pend_v[i] = 1'b0; pend_o[i] = 8'd0; pend_f[i] = 1'b0;
            end
        end else begin
            e_v = pend_v[0]; e_out = pend_o[0]; e_ovf = pend_f[0];
            pend_v[0] = pend_v[1]; pend_o[0] = pend_o[1]; pend_f[0] = pend_f[1];
            if (v) begin
                s = 0;
                for (int i = 0; i < N; i++) s += int'(a[i*W +: W]) * int'(b[i*W +: W]);
                if (!ae) begin
                    m_out = 8'(s);
                end else if (cl) begin
                    m_acc = s; m_out = 8'(s); m_ovf = 1'b0;
                end else begin
                    m_acc = m_acc + s;
                    if (m_acc > 255) begin
                        m_acc = 255; m_ovf = 1'b1;
                    end
                    m_out = 8'(m_acc);
                end
            end
            pend_v[1] = v; pend_o[1] = m_out; pend_f[1] = m_ovf;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 2) step(1'b1, 1'b1, 1'b1, 1'b0, V18, V18);
            else       step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
            checks++;
            if (out_valid !== 1'b0 || out !== 8'd0 || ovf !== 1'b0) begin
                errors++;
                $display("FAIL reset cycle %0d: got v=%0b out=%0d ovf=%0b, want v=0 out=0 ovf=0",
                         i, out_valid, out, ovf);
            end
        end
    endtask

    task automatic test_pass_through();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       step(1'b0, 1'b1, 1'b0, 1'b0, V5, V5);
                1:       step(1'b0, 1'b1, 1'b0, 1'b0, V18, V18);
                default: step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
            endcase
            checks++;
            if (out_valid !== e_v || out !== e_out || ovf !== e_ovf) begin
                errors++;
                $display("FAIL pass_model step %0d: got v=%0b out=%0d ovf=%0b, want v=%0b out=%0d ovf=%0b",
                         i, out_valid, out, ovf, e_v, e_out, e_ovf);
            end
            if (i == 2 || i == 3) begin
                checks++;
                if (out_valid !== 1'b1 || out !== ((i == 2) ? 8'd5 : 8'd18)) begin
                    errors++;
                    $display("FAIL pass_value step %0d: got v=%0b out=%0d, want v=1 out=%0d",
                             i, out_valid, out, (i == 2) ? 5 : 18);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) step(1'b0, 1'b1, 1'b1, i == 0, V18, V18);
            else       step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
            checks++;
            if (out_valid !== e_v || out !== e_out || ovf !== e_ovf) begin
                errors++;
                $display("FAIL b2b_model step %0d: got v=%0b out=%0d ovf=%0b, want v=%0b out=%0d ovf=%0b",
                         i, out_valid, out, ovf, e_v, e_out, e_ovf);
            end
            if (i >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out !== 8'(18 * (i - 1))) begin
                    errors++;
                    $display("FAIL b2b_value step %0d: got v=%0b out=%0d, want v=1 out=%0d",
                             i, out_valid, out, 18 * (i - 1));
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] want_o;
        logic       want_f;
        for (int i = 0; i < 15; i++) begin
            if (i < 12)       step(1'b0, 1'b1, 1'b1, 1'b0, V18, V18);
            else if (i == 12) step(1'b0, 1'b1, 1'b1, 1'b1, V5, V5);
            else              step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
            checks++;
            if (out_valid !== e_v || out !== e_out || ovf !== e_ovf) begin
                errors++;
                $display("FAIL sat_model step %0d: got v=%0b out=%0d ovf=%0b, want v=%0b out=%0d ovf=%0b",
                         i, out_valid, out, ovf, e_v, e_out, e_ovf);
            end
            if (i >= 2) begin
                if (i <= 11)      begin want_o = 8'(72 + 18 * (i - 1)); want_f = 1'b0; end
                else if (i <= 13) begin want_o = 8'd255;                want_f = 1'b1; end
                else              begin want_o = 8'd5;                  want_f = 1'b0; end
                checks++;
                if (out_valid !== 1'b1 || out !== want_o || ovf !== want_f) begin
                    errors++;
                    $display("FAIL sat_value step %0d: got v=%0b out=%0d ovf=%0b, want v=1 out=%0d ovf=%0b",
                             i, out_valid, out, ovf, want_o, want_f);
                end
            end
        end
    endtask

    task automatic test_bubbles();
        for (int i = 0; i < 6; i++) begin
            if (i == 0)      step(1'b0, 1'b1, 1'b1, 1'b1, V5, V5);
            else if (i == 3) step(1'b0, 1'b1, 1'b1, 1'b0, V5, V5);
            else             step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
            checks++;
            if (out_valid !== e_v || out !== e_out || ovf !== e_ovf) begin
                errors++;
                $display("FAIL bubble_model step %0d: got v=%0b out=%0d ovf=%0b, want v=%0b out=%0d ovf=%0b",
                         i, out_valid, out, ovf, e_v, e_out, e_ovf);
            end
            if (i >= 2) begin
                checks++;
                if (out_valid !== (i == 2 || i == 5) || out !== ((i == 5) ? 8'd10 : 8'd5)) begin
                    errors++;
                    $display("FAIL bubble_value step %0d: got v=%0b out=%0d, want v=%0b out=%0d",
                             i, out_valid, out, (i == 2 || i == 5), (i == 5) ? 10 : 5);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       step(1'b0, 1'b1, 1'b1, 1'b1, V5, V5);
                1:       step(1'b0, 1'b1, 1'b1, 1'b0, V18, V18);
                2:       step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
                3:       step(1'b0, 1'b1, 1'b1, 1'b0, V5, V5);
                default: step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
            endcase
            checks++;
            if (out_valid !== e_v || out !== e_out || ovf !== e_ovf) begin
                errors++;
                $display("FAIL rstmid_model step %0d: got v=%0b out=%0d ovf=%0b, want v=%0b out=%0d ovf=%0b",
                         i, out_valid, out, ovf, e_v, e_out, e_ovf);
            end
            if (i >= 2) begin
                checks++;
                if (out_valid !== (i == 5) || out !== ((i == 5) ? 8'd5 : 8'd0) || ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL rstmid_value step %0d: got v=%0b out=%0d ovf=%0b, want v=%0b out=%0d ovf=0",
                             i, out_valid, out, ovf, (i == 5), (i == 5) ? 5 : 0);
                end
            end
        end
    endtask

    task automatic test_random();
        logic r, v, ae, cl;
        logic [3:0] a, b;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            v  = ($urandom_range(0, 3) != 0);
            ae = ($urandom_range(0, 4) != 0);
            cl = ($urandom_range(0, 7) == 0);
            a  = 4'($urandom);
            b  = 4'($urandom);
            step(r, v, ae, cl, a, b);
            checks++;
            if (out_valid !== e_v || out !== e_out || ovf !== e_ovf) begin
                errors++;
                $display("FAIL random step %0d: got v=%0b out=%0d ovf=%0b, want v=%0b out=%0d ovf=%0b",
                         i, out_valid, out, ovf, e_v, e_out, e_ovf);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        m_acc = 0; m_out = 8'd0; m_ovf = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pend_v[i] = 1'b0; pend_o[i] = 8'd0; pend_f[i] = 1'b0;
        end
        rst = 1'b1; in_valid = 1'b0; acc_en = 1'b0; clear = 1'b0;
        a_vec = '0; b_vec = '0;
        test_reset();
        test_pass_through();
        test_back_to_back();
        test_saturation();
        test_bubbles();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
